multicycle_ctrl: RTL and testbench

Multi-cycle sequencing controller for the RV32I core. It consumes the per-instruction control bits produced by the main decoder and steps the shared datapath through FETCH, DECODE, EXEC, MEM and WB. It generates every write-enable, the PC update, and the instruction/data memory request handshakes. It also keeps a retired-instruction counter and stops in a sticky HALT state on an illegal opcode.

---
 rtl/multicycle_ctrl_if.sv | 53 +++++
 rtl/multicycle_ctrl.sv | 143 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Bundle of decoder controls, memory handshakes and datapath enables
// exchanged between the multicycle sequencer and the rest of the core.
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   // Fetch permission
   logic             run;

   // Decoder control bits, held from DECODE to the end of the instruction
   logic             reg_wen;
   logic             mem_rw;
   logic             mem_to_reg;
   logic             branch;
   logic             jump;
   logic             illegal;

   // Branch comparator result, valid in EXEC
   logic             br_taken;

   // Memory handshake returns
   logic             imem_ready;
   logic             dmem_ready;

   // Memory requests and datapath enables
   logic             imem_req;
   logic             ir_we;
   logic             dmem_req;
   logic             dmem_we;
   logic             rf_we;
   logic             pc_we;
   logic             pc_sel;

   // Status
   logic             halted;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired;

   // The sequencer drives requests, enables and status
   modport master (
      input  run, reg_wen, mem_rw, mem_to_reg, branch, jump, illegal,
             br_taken, imem_ready, dmem_ready,
      output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
             halted, state, retired
   );

   // Decoder, memories and datapath side
   modport slave (
      output run, reg_wen, mem_rw, mem_to_reg, branch, jump, illegal,
             br_taken, imem_ready, dmem_ready,
      input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
             halted, state, retired
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the RV32I core.
// Steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB, issues the
// instruction and data memory requests, generates every write enable and
// the PC update, counts retired instructions and parks in HALT on an
// illegal opcode until reset.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             fetch_pend_q, fetch_pend_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic             imem_req;
   logic             ir_we;
   logic             dmem_req;
   logic             dmem_we;
   logic             rf_we;
   logic             pc_we;
   logic             pc_sel;
   logic             mem_access;

   // A load or a store both need the MEM phase; when the decoder flags both,
   // mem_rw wins everywhere below so the instruction behaves as a store.
   assign mem_access = bus.mem_to_reg | bus.mem_rw;

   // Next-state, pending-fetch flag, enables and retirement count
   always_comb begin
      state_d      = state_q;
      fetch_pend_d = fetch_pend_q;
      imem_req     = 1'b0;
      ir_we        = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      rf_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;

      case (state_q)
         S_FETCH: begin
            // Once issued, the request is held until accepted even if run drops.
            imem_req = bus.run | fetch_pend_q;
            if (imem_req && bus.imem_ready) begin
               ir_we        = 1'b1;
               fetch_pend_d = 1'b0;
               state_d      = S_DECODE;
            end else if (imem_req) begin
               fetch_pend_d = 1'b1;
            end
         end

         S_DECODE: begin
            state_d = bus.illegal ? S_HALT : S_EXEC;
         end

         S_EXEC: begin
            if (mem_access) begin
               state_d = S_MEM;
            end else if (bus.reg_wen) begin
               state_d = S_WB;
            end else begin
               // Branch-only instruction retires straight out of EXEC.
               pc_we   = 1'b1;
               pc_sel  = bus.branch & bus.br_taken;
               state_d = S_FETCH;
            end
         end

         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = bus.mem_rw;
            if (bus.dmem_ready) begin
               if (bus.mem_rw) begin
                  // Store retires here; nothing to write back.
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            rf_we   = bus.reg_wen;
            pc_we   = 1'b1;
            pc_sel  = bus.jump;
            state_d = S_FETCH;
         end

         S_HALT: begin
            // Sticky: only reset leaves this state.
            state_d = S_HALT;
         end

         default: begin
            // Unused encodings fall back to a clean fetch.
            state_d      = S_FETCH;
            fetch_pend_d = 1'b0;
         end
      endcase

      // Retirement is marked by the PC update; wraps freely.
      retired_d = retired_q + CNT_W'(pc_we);
   end

   // State, pending-fetch flag and retired counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         fetch_pend_q <= 1'b0;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pend_q <= fetch_pend_d;
         retired_q    <= retired_d;
      end
   end

   assign bus.imem_req = imem_req;
   assign bus.ir_we    = ir_we;
   assign bus.dmem_req = dmem_req;
   assign bus.dmem_we  = dmem_we;
   assign bus.rf_we    = rf_we;
   assign bus.pc_we    = pc_we;
   assign bus.pc_sel   = pc_sel;
   assign bus.halted   = (state_q == S_HALT);
   assign bus.state    = state_q;
   assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (CNT_W=4 so counter wrap is reachable).
// Every cycle compares state plus the packed control vector
// {halted, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel}.
module tb_multicycle_ctrl;

   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(CW)) bus ();

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // Set decoder controls: reg_wen, mem_rw, mem_to_reg, branch, jump, illegal
   task automatic set_dec(input logic rw, input logic mw, input logic mr,
                          input logic br, input logic jp, input logic il);
      bus.reg_wen    = rw;
      bus.mem_rw     = mw;
      bus.mem_to_reg = mr;
      bus.branch     = br;
      bus.jump       = jp;
      bus.illegal    = il;
   endtask

   // Settle, compare this cycle's outputs, then advance one clock
   task automatic chk(input string tag, input logic [2:0] st, input logic [7:0] ctl);
      logic [10:0] obs;
      logic [10:0] exp_v;
      #1;
      obs   = {bus.state, bus.halted, bus.imem_req, bus.ir_we, bus.dmem_req,
               bus.dmem_we, bus.rf_we, bus.pc_we, bus.pc_sel};
      exp_v = {st, ctl};
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed st=%0d ctl=%b, expected st=%0d ctl=%b",
                tag, obs[10:8], obs[7:0], exp_v[10:8], exp_v[7:0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ret(input string tag, input logic [CW-1:0] exp_v);
      n_cmp++;
      assert (bus.retired === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed retired=%0d, expected %0d", tag, bus.retired, exp_v);
      end
   endtask

   initial begin
      bus.run        = 1'b0;
      bus.br_taken   = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      set_dec(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state: idle FETCH, counter clear
      chk_ret("rst_ret", 4'd0);
      chk("rst_idle", 3'd0, 8'b0000_0000);
      chk("idle_run0", 3'd0, 8'b0000_0000);

      // ADD, zero wait
      bus.run = 1'b1; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
      set_dec(1, 0, 0, 0, 0, 0);
      chk("add_f", 3'd0, 8'b0110_0000);
      chk("add_d", 3'd1, 8'b0000_0000);
      chk("add_e", 3'd2, 8'b0000_0000);
      chk("add_w", 3'd4, 8'b0000_0110);
      chk_ret("add_ret", 4'd1);

      // Load with dmem_ready low for two cycles: 7 cycles total
      set_dec(1, 0, 1, 0, 0, 0);
      bus.dmem_ready = 1'b0;
      chk("ld_f", 3'd0, 8'b0110_0000);
      chk("ld_d", 3'd1, 8'b0000_0000);
      chk("ld_e", 3'd2, 8'b0000_0000);
      chk("ld_m1", 3'd3, 8'b0001_0000);
      chk("ld_m2", 3'd3, 8'b0001_0000);
      bus.dmem_ready = 1'b1;
      chk("ld_m3", 3'd3, 8'b0001_0000);
      chk("ld_w", 3'd4, 8'b0000_0110);
      chk_ret("ld_ret", 4'd2);

      // Store, zero wait: retires from MEM with pc_sel=0
      set_dec(0, 1, 0, 0, 0, 0);
      chk("st_f", 3'd0, 8'b0110_0000);
      chk("st_d", 3'd1, 8'b0000_0000);
      chk("st_e", 3'd2, 8'b0000_0000);
      chk("st_m", 3'd3, 8'b0001_1010);

      // Decoder fault (load+store+reg_wen) behaves as a store, no rf_we
      set_dec(1, 1, 1, 0, 0, 0);
      chk("flt_f", 3'd0, 8'b0110_0000);
      chk("flt_d", 3'd1, 8'b0000_0000);
      chk("flt_e", 3'd2, 8'b0000_0000);
      chk("flt_m", 3'd3, 8'b0001_1010);
      chk_ret("st_ret", 4'd4);

      // Branch taken then not taken: 3 cycles each, pc_we in EXEC
      set_dec(0, 0, 0, 1, 0, 0);
      bus.br_taken = 1'b1;
      chk("bt_f", 3'd0, 8'b0110_0000);
      chk("bt_d", 3'd1, 8'b0000_0000);
      chk("bt_e", 3'd2, 8'b0000_0011);
      bus.br_taken = 1'b0;
      chk("bn_f", 3'd0, 8'b0110_0000);
      chk("bn_d", 3'd1, 8'b0000_0000);
      chk("bn_e", 3'd2, 8'b0000_0010);
      chk_ret("br_ret", 4'd6);

      // JAL: writeback with pc_sel=1
      set_dec(1, 0, 0, 0, 1, 0);
      chk("jal_f", 3'd0, 8'b0110_0000);
      chk("jal_d", 3'd1, 8'b0000_0000);
      chk("jal_e", 3'd2, 8'b0000_0000);
      chk("jal_w", 3'd4, 8'b0000_0111);
      chk_ret("jal_ret", 4'd7);

      // Fetch stall; run drops while imem_ready stays low for 3 cycles
      set_dec(1, 0, 0, 0, 0, 0);
      bus.imem_ready = 1'b0;
      chk("fs_1", 3'd0, 8'b0100_0000);
      bus.run = 1'b0;
      chk("fs_2", 3'd0, 8'b0100_0000);
      chk("fs_3", 3'd0, 8'b0100_0000);
      chk("fs_4", 3'd0, 8'b0100_0000);
      bus.imem_ready = 1'b1;
      chk("fs_acc", 3'd0, 8'b0110_0000);
      chk("fs_d", 3'd1, 8'b0000_0000);
      chk("fs_e", 3'd2, 8'b0000_0000);
      chk("fs_w", 3'd4, 8'b0000_0110);
      chk_ret("fs_ret", 4'd8);
      // Pending flag must be clear: run=0 stays idle
      chk("fs_idle1", 3'd0, 8'b0000_0000);
      chk("fs_idle2", 3'd0, 8'b0000_0000);

      // Seven not-taken branches bring the counter to 15, one more wraps to 0
      bus.run = 1'b1;
      set_dec(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 7; i++) begin
         chk("wr_f", 3'd0, 8'b0110_0000);
         chk("wr_d", 3'd1, 8'b0000_0000);
         chk("wr_e", 3'd2, 8'b0000_0010);
      end
      chk_ret("wr_15", 4'd15);
      chk("wr_lf", 3'd0, 8'b0110_0000);
      chk("wr_ld", 3'd1, 8'b0000_0000);
      chk("wr_le", 3'd2, 8'b0000_0010);
      chk_ret("wr_wrap", 4'd0);

      // Reset in the middle of a stalled load
      set_dec(1, 0, 1, 0, 0, 0);
      bus.dmem_ready = 1'b0;
      chk("rm_f", 3'd0, 8'b0110_0000);
      chk("rm_d", 3'd1, 8'b0000_0000);
      chk("rm_e", 3'd2, 8'b0000_0000);
      chk("rm_m1", 3'd3, 8'b0001_0000);
      rst = 1'b1;
      chk("rm_rst", 3'd3, 8'b0001_0000);
      rst = 1'b0;
      bus.run = 1'b0;
      chk("rm_after", 3'd0, 8'b0000_0000);

      // Retire one ADD, then an illegal opcode parks in HALT
      bus.run = 1'b1; bus.dmem_ready = 1'b1;
      set_dec(1, 0, 0, 0, 0, 0);
      chk("pa_f", 3'd0, 8'b0110_0000);
      chk("pa_d", 3'd1, 8'b0000_0000);
      chk("pa_e", 3'd2, 8'b0000_0000);
      chk("pa_w", 3'd4, 8'b0000_0110);
      set_dec(1, 1, 1, 1, 1, 1);
      bus.br_taken = 1'b1;
      chk("il_f", 3'd0, 8'b0110_0000);
      chk("il_d", 3'd1, 8'b0000_0000);
      for (int i = 0; i < 12; i++) begin
         chk("il_halt", 3'd5, 8'b1000_0000);
      end
      chk_ret("il_ret", 4'd1);

      // Reset exits HALT; run=1 requests a fetch right away
      rst = 1'b1;
      chk("il_rst", 3'd5, 8'b1000_0000);
      rst = 1'b0;
      chk_ret("il_rst_ret", 4'd0);
      set_dec(0, 0, 0, 0, 0, 0);
      bus.imem_ready = 1'b0;
      chk("post_rst", 3'd0, 8'b0100_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
